// File: rtl/debounce_pkg.sv
// Shared constants for the debounce_sync input conditioner: FSM encoding and parameter defaults.
// Latency: n/a (package). Backpressure: n/a.
package debounce_pkg;

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH   = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW    = 2'd3;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/debounce_sync_if.sv
// Signal bundle between a debounce_sync block and its user; edge pulses exist only with DEBOUNCE_SYNC_EDGE_EN.
// Latency: n/a (wires). Backpressure: none, level/pulse signals only.
interface debounce_sync_if;

  logic signal_in;
  logic sample_tick;
  logic signal_out;
  logic signal_out_neg;
`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic rise_pulse;
  logic fall_pulse;

  modport master (
    output signal_in,
    output sample_tick,
    input  signal_out,
    input  signal_out_neg,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  signal_in,
    input  sample_tick,
    output signal_out,
    output signal_out_neg,
    output rise_pulse,
    output fall_pulse
  );
`else
  modport master (
    output signal_in,
    output sample_tick,
    input  signal_out,
    input  signal_out_neg
  );

  modport slave (
    input  signal_in,
    input  sample_tick,
    output signal_out,
    output signal_out_neg
  );
`endif

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous bit into the clock_pos domain.
// Latency: STAGES edges. Backpressure: none, samples every edge.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock_pos,
  input  logic reset_neg,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clock_pos) begin
    if (!reset_neg) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce a bouncing external input into a clean level; optional edge pulses with DEBOUNCE_SYNC_EDGE_EN.
// Latency: SYNC_STAGES edges + DEBOUNCE_CYCLES qualifying sample_tick edges. Backpressure: none, sample_tick=0 freezes the filter.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock_pos,
  input  logic reset_neg,
  debounce_sync_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 out_q, out_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock_pos (clock_pos),
    .reset_neg (reset_neg),
    .d         (bus.signal_in),
    .q         (s)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    out_d   = out_q;
    if (bus.sample_tick) begin
      case (state_q)
        ST_STABLE_LOW: begin
          if (s) begin
            // A single-sample filter accepts immediately and never waits
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = ST_STABLE_HIGH;
              out_d   = 1'b1;
            end else begin
              state_d = ST_WAIT_HIGH;
              count_d = CNT_WIDTH'(1);
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (!s) begin
            state_d = ST_STABLE_LOW;
            count_d = '0;
          end else if (count_q == LAST_CNT) begin
            state_d = ST_STABLE_HIGH;
            out_d   = 1'b1;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
        ST_STABLE_HIGH: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = ST_STABLE_LOW;
              out_d   = 1'b0;
            end else begin
              state_d = ST_WAIT_LOW;
              count_d = CNT_WIDTH'(1);
            end
          end
        end
        ST_WAIT_LOW: begin
          if (s) begin
            state_d = ST_STABLE_HIGH;
            count_d = '0;
          end else if (count_q == LAST_CNT) begin
            state_d = ST_STABLE_LOW;
            out_d   = 1'b0;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_STABLE_LOW;
          count_d = '0;
          out_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_pos) begin
    if (!reset_neg) begin
      state_q <= ST_STABLE_LOW;
      count_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
    end
  end

  assign bus.signal_out     = out_q;
  assign bus.signal_out_neg = ~out_q;

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic rise_q, fall_q;

  // Pulses are registered with out_q so they line up with the first cycle of the new level
  always_ff @(posedge clock_pos) begin
    if (!reset_neg) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: defaults, gated sample_tick with DEBOUNCE_CYCLES=3, and DEBOUNCE_CYCLES=1 with SYNC_STAGES=3.
module tb_debounce_sync;

  logic clk;
  logic reset_neg;
  int   n_checks;
  int   n_fail;
  int   bad;
  logic exp_lvl;

  debounce_sync_if if0 ();
  debounce_sync_if if1 ();
  debounce_sync_if if2 ();

  debounce_sync u0 (
    .clock_pos (clk),
    .reset_neg (reset_neg),
    .bus       (if0)
  );

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(3)) u1 (
    .clock_pos (clk),
    .reset_neg (reset_neg),
    .bus       (if1)
  );

  debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) u2 (
    .clock_pos (clk),
    .reset_neg (reset_neg),
    .bus       (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_neg       = 1'b0;
    if0.signal_in   = 1'b1;
    if0.sample_tick = 1'b1;
    if1.signal_in   = 1'b0;
    if1.sample_tick = 1'b1;
    if2.signal_in   = 1'b0;
    if2.sample_tick = 1'b1;

    // Reset with input held high
    step(3);
    check("rst_out", if0.signal_out, 0);
    check("rst_out_neg", if0.signal_out_neg, 1);
    check("rst_state", u0.state_q, 0);
    check("rst_count", u0.count_q, 0);
`ifdef DEBOUNCE_SYNC_EDGE_EN
    check("rst_rise", if0.rise_pulse, 0);
    check("rst_fall", if0.fall_pulse, 0);
`endif

    // Release: input already high is accepted at edge 18
    reset_neg = 1'b1;
    step(17);
    check("rel_out_e17", if0.signal_out, 0);
    step(1);
    check("rel_out_e18", if0.signal_out, 1);
    check("rel_neg_e18", if0.signal_out_neg, 0);
`ifdef DEBOUNCE_SYNC_EDGE_EN
    check("rel_rise_e18", if0.rise_pulse, 1);
`endif
    step(1);
    check("rel_out_e19", if0.signal_out, 1);
`ifdef DEBOUNCE_SYNC_EDGE_EN
    check("rel_rise_e19", if0.rise_pulse, 0);
`endif

    // Clean fall
    if0.signal_in = 1'b0;
    step(17);
    check("fall_out_e17", if0.signal_out, 1);
    step(1);
    check("fall_out_e18", if0.signal_out, 0);
    check("fall_neg_e18", if0.signal_out_neg, 1);
`ifdef DEBOUNCE_SYNC_EDGE_EN
    check("fall_pulse_e18", if0.fall_pulse, 1);
    check("fall_rise_e18", if0.rise_pulse, 0);
`endif
    step(1);
`ifdef DEBOUNCE_SYNC_EDGE_EN
    check("fall_pulse_e19", if0.fall_pulse, 0);
`endif

    // 15-sample glitch is rejected
    bad = 0;
    if0.signal_in = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i == 15) if0.signal_in = 1'b0;
      step(1);
      if (if0.signal_out !== 1'b0) bad++;
`ifdef DEBOUNCE_SYNC_EDGE_EN
      if (if0.rise_pulse !== 1'b0) bad++;
`endif
    end
    check("glitch15_reject", bad, 0);
    check("glitch15_state", u0.state_q, 0);
    check("glitch15_count", u0.count_q, 0);

    // 16-sample pulse is accepted
    if0.signal_in = 1'b1;
    step(16);
    if0.signal_in = 1'b0;
    step(1);
    check("pulse16_e17", if0.signal_out, 0);
    step(1);
    check("pulse16_e18", if0.signal_out, 1);
`ifdef DEBOUNCE_SYNC_EDGE_EN
    check("pulse16_rise", if0.rise_pulse, 1);
`endif
    step(20);
    check("pulse16_settle", if0.signal_out, 0);
    check("pulse16_state", u0.state_q, 0);

    // Reset in the middle of WAIT_HIGH
    if0.signal_in = 1'b1;
    step(12);
    check("midwait_state", u0.state_q, 1);
    check("midwait_count", u0.count_q, 10);
    reset_neg = 1'b0;
    step(1);
    check("midrst_state", u0.state_q, 0);
    check("midrst_count", u0.count_q, 0);
    check("midrst_out", if0.signal_out, 0);
`ifdef DEBOUNCE_SYNC_EDGE_EN
    check("midrst_rise", if0.rise_pulse, 0);
`endif
    if0.signal_in = 1'b0;
    reset_neg = 1'b1;
    step(2);

    // Gated sampling: tick every 4th edge, DEBOUNCE_CYCLES=3, accept at edge 12
    bad = 0;
    if1.signal_in = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if1.sample_tick = (k % 4 == 0);
      step(1);
      if (k < 12 && if1.signal_out !== 1'b0) bad++;
      if (k >= 12 && if1.signal_out !== 1'b1) bad++;
      if (k == 12) begin
        check("tick_accept_e12", if1.signal_out, 1);
`ifdef DEBOUNCE_SYNC_EDGE_EN
        check("tick_rise_e12", if1.rise_pulse, 1);
`endif
      end
      if (k == 11) check("tick_hold_e11", if1.signal_out, 0);
`ifdef DEBOUNCE_SYNC_EDGE_EN
      if (k == 13) check("tick_rise_e13", if1.rise_pulse, 0);
`endif
    end
    check("tick_level_trace", bad, 0);
    if1.sample_tick = 1'b1;

    // DEBOUNCE_CYCLES=1, SYNC_STAGES=3: follow each toggle after exactly 4 edges
    for (int t = 0; t < 4; t++) begin
      if2.signal_in = ~if2.signal_in;
      exp_lvl = if2.signal_in;
      step(3);
      check("dc1_e3_old", if2.signal_out, !exp_lvl);
      step(1);
      check("dc1_e4_new", if2.signal_out, exp_lvl);
`ifdef DEBOUNCE_SYNC_EDGE_EN
      check("dc1_rise", if2.rise_pulse, exp_lvl);
      check("dc1_fall", if2.fall_pulse, !exp_lvl);
`endif
      step(2);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
